peripheral_dbg_soc_ring_router_mux_rr_param: RTL and testbench
==============================================================

Name: peripheral_dbg_soc_ring_router_mux_rr_param

Overview:
- N-input, worm-aware round-robin flit multiplexer for the DII debug ring router. It generalises the fixed two-input router mux.
- Merges CHANNELS independent valid/ready flit streams onto one output stream. A multi-flit packet (worm) is never interleaved with another.
- Adds an optional registered output stage for timing closure.
- Adds status outputs (current grant, worm active) for debug and the ring router's local arbitration.

Parameters:
- CHANNELS, 4, number of input streams; legal range >= 2.
- DATA_WIDTH, 16, flit payload width in bits.
- OUT_REG, 0, 0 = combinational output path; 1 = one-entry registered output stage, full throughput.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to clk.
- in_data  in  CHANNELS*DATA_WIDTH  flit payload; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  CHANNELS  last-flit-of-packet marker, per channel.
- in_valid  in  CHANNELS  flit valid, per channel.
- in_ready  out  CHANNELS  flit accepted, per channel.
- out_data  out  DATA_WIDTH  muxed flit payload.
- out_last  out  1  muxed last marker.
- out_valid  out  1  muxed flit valid.
- out_ready  in  1  downstream accepts the flit.
- grant_idx  out  $clog2(CHANNELS)  currently selected channel.
- worm_active  out  1  selection is locked (packet in progress or stalled presented flit).

Behaviour:
- Transfer definition: input transfer on in_valid[g] & in_ready[g]; output transfer on out_valid & out_ready.
- Internal state: locked (1 bit), grant g, rr pointer ptr (last channel that completed a packet).
- Reset values: locked = 0, g = 0, ptr = CHANNELS-1 (so channel 0 has first priority), out_valid = 0, out_data = 0, out_last = 0, in_ready = 0, grant_idx = 0, worm_active = 0.
- Arbitration while unlocked: select the first channel with in_valid set, scanning ptr+1, ptr+2, ... modulo CHANNELS. This decision is same-cycle (combinational); grant_idx shows it. If no input is valid: out_valid = 0 (OUT_REG=0) and no state change.
- Arbitration while locked: g is held; no other channel is considered.
- in_ready[i] = 0 for every i != g.
- OUT_REG=0 path: out_* = in_*[g]; in_ready[g] = out_ready.
- Lock rule (OUT_REG=0): next locked = 1 if a flit of g is presented and either (a) not transferred, or (b) transferred with last = 0. This guarantees out_data/out_last/out_valid never change while a flit waits for out_ready.
- Unlock rule: a transfer with last = 1 sets locked = 0 and ptr = g, in the same edge.
- Single-flit packets: a transferred single flit (last = 1) updates ptr, so priority rotates after every packet.
- OUT_REG=1 path: output register holds one flit. in_ready[g] = !out_valid | out_ready.
  - An input transfer loads the register and sets out_valid next cycle; latency is exactly 1 cycle.
  - Output transfer with no simultaneous load: out_valid clears.
  - Simultaneous load and unload: the register is replaced, giving 1 flit per cycle sustained.
  - Lock/unlock rules apply to input transfers. With OUT_REG=1 the case "presented but not transferred" does not lock, because nothing is committed until transfer.
- Locked channel drops in_valid mid-worm: out_valid = 0 (OUT_REG=0), or no load (OUT_REG=1). The lock is held and no other channel is served until channel g delivers its last flit.
- Simultaneous valid on all channels with one-flit packets: grants go strictly 0,1,...,CHANNELS-1,0,...
- ptr wrap: ptr = CHANNELS-1 scans from channel 0. Non-power-of-2 CHANNELS must wrap correctly; grant_idx never exceeds CHANNELS-1.
- Reset mid-worm: all state returns to reset values immediately, asynchronously. Any registered flit is discarded and there is no partial-packet memory.
- worm_active = locked. grant_idx = g when locked, else the combinational winner (or the previous g if none valid).

Test Plan:
- CHANNELS=4, OUT_REG=0; all four channels present 1-flit packets continuously, out_ready=1 → grant order 0,1,2,3,0,1; one output flit per cycle; each in_ready pulses only for its own grant.
- Channel 2 sends a 3-flit worm (last on flit 3) while channels 0 and 3 are valid → output shows the three ch2 flits contiguous; ptr becomes 2; next grant is 3, then 0.
- OUT_REG=0; ch1 presents data 0xA5A5 with out_ready=0 for 3 cycles while ch0 asserts valid → out_data stays 0xA5A5 and worm_active=1; ch1 transfers on the 4th cycle; ch0 is granted next.
- OUT_REG=1, CHANNELS=3; back-to-back flits with out_ready=1 → 1-cycle latency, 1 flit/cycle. Toggling out_ready 1/0 → no loss, no duplication, order preserved.
- Ch0 mid-worm (flit 2 of 4) when rst is pulled low asynchronously → out_valid=0, worm_active=0, grant_idx=0 immediately. After release, ch3 alone valid is granted on the first cycle.
- CHANNELS=5, DATA_WIDTH=8; only ch4 valid, then only ch0 valid → ptr wraps 4→0 correctly; grant_idx never reads 5–7.

Source files
------------

// File: rtl/peripheral_dbg_soc_ring_router_mux_rr_param.sv
// N-input worm-aware round-robin flit multiplexer for the DII debug ring router.
// Packets are never interleaved; an optional one-entry output register keeps full throughput.
module peripheral_dbg_soc_ring_router_mux_rr_param #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]            in_last,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(CHANNELS)-1:0]    grant_idx,
    output logic                           worm_active
);

    localparam int unsigned GW = $clog2(CHANNELS);

    logic                  locked_q, locked_d;
    logic [GW-1:0]         g_q, g_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic                  oreg_valid_q, oreg_valid_d;
    logic                  oreg_last_q, oreg_last_d;
    logic [DATA_WIDTH-1:0] oreg_data_q, oreg_data_d;

    logic [DATA_WIDTH-1:0] ch_data [CHANNELS];
    logic [GW-1:0]         win;
    logic [GW-1:0]         cand;
    logic                  found;
    logic [GW-1:0]         sel;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  sel_ready;
    logic                  xfer;

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            ch_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan ptr+1, ptr+2, ... modulo CHANNELS; with nothing valid the old grant is kept.
    always_comb begin
        win   = g_q;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            cand = GW'((32'(ptr_q) + k) % CHANNELS);
            if (!found && in_valid[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel       = locked_q ? g_q : win;
        sel_valid = in_valid[sel];
        sel_last  = in_last[sel];
    end

    always_comb begin
        in_ready     = '0;
        out_data     = '0;
        out_last     = 1'b0;
        out_valid    = 1'b0;
        sel_ready    = 1'b0;
        xfer         = 1'b0;
        locked_d     = locked_q;
        ptr_d        = ptr_q;
        g_d          = sel;
        oreg_valid_d = oreg_valid_q;
        oreg_last_d  = oreg_last_q;
        oreg_data_d  = oreg_data_q;

        if (OUT_REG == 0) begin
            sel_ready = out_ready;
            out_valid = sel_valid;
            out_data  = ch_data[sel];
            out_last  = sel_last;
        end else begin
            sel_ready = !oreg_valid_q || out_ready;
            out_valid = oreg_valid_q;
            out_data  = oreg_data_q;
            out_last  = oreg_last_q;
        end

        xfer          = sel_valid && sel_ready;
        in_ready[sel] = sel_ready;

        if (OUT_REG != 0) begin
            if (xfer) begin
                oreg_valid_d = 1'b1;
                oreg_data_d  = ch_data[sel];
                oreg_last_d  = sel_last;
            end else if (out_ready) begin
                oreg_valid_d = 1'b0;
            end
        end

        // A combinational path must hold a presented but stalled flit, so it locks too.
        if (xfer) begin
            locked_d = !sel_last;
            if (sel_last) begin
                ptr_d = sel;
            end
        end else if (sel_valid && (OUT_REG == 0)) begin
            locked_d = 1'b1;
        end

        grant_idx   = sel;
        worm_active = locked_q;

        if (!rst) begin
            in_ready    = '0;
            out_data    = '0;
            out_last    = 1'b0;
            out_valid   = 1'b0;
            grant_idx   = '0;
            worm_active = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked_q     <= 1'b0;
            g_q          <= '0;
            ptr_q        <= GW'(CHANNELS - 1);
            oreg_valid_q <= 1'b0;
            oreg_last_q  <= 1'b0;
            oreg_data_q  <= '0;
        end else begin
            locked_q     <= locked_d;
            g_q          <= g_d;
            ptr_q        <= ptr_d;
            oreg_valid_q <= oreg_valid_d;
            oreg_last_q  <= oreg_last_d;
            oreg_data_q  <= oreg_data_d;
        end
    end

endmodule

// File: tb/tb_peripheral_dbg_soc_ring_router_mux_rr_param.sv
// Randomised and directed bench for the round-robin flit mux: three configurations
// (4ch comb, 3ch registered, 5ch/8-bit comb) checked against a packet-level reference model.
module tb_peripheral_dbg_soc_ring_router_mux_rr_param;

    int nch  [3] = '{4, 3, 5};
    int oreg [3] = '{0, 1, 0};
    int dw   [3] = '{16, 16, 8};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  vld_v  [3];
    logic [4:0]  last_v [3];
    logic [15:0] dat_v  [3][5];
    logic        ordy_v [3];

    logic [3:0]  ird_a;  logic [15:0] od_a; logic ol_a, ov_a, wa_a; logic [1:0] gi_a;
    logic [2:0]  ird_b;  logic [15:0] od_b; logic ol_b, ov_b, wa_b; logic [1:0] gi_b;
    logic [4:0]  ird_c;  logic [7:0]  od_c; logic ol_c, ov_c, wa_c; logic [2:0] gi_c;

    peripheral_dbg_soc_ring_router_mux_rr_param #(.CHANNELS(4), .DATA_WIDTH(16), .OUT_REG(0)) u_a (
        .clk(clk), .rst(rst),
        .in_data({dat_v[0][3], dat_v[0][2], dat_v[0][1], dat_v[0][0]}),
        .in_last(last_v[0][3:0]), .in_valid(vld_v[0][3:0]), .in_ready(ird_a),
        .out_data(od_a), .out_last(ol_a), .out_valid(ov_a), .out_ready(ordy_v[0]),
        .grant_idx(gi_a), .worm_active(wa_a));

    peripheral_dbg_soc_ring_router_mux_rr_param #(.CHANNELS(3), .DATA_WIDTH(16), .OUT_REG(1)) u_b (
        .clk(clk), .rst(rst),
        .in_data({dat_v[1][2], dat_v[1][1], dat_v[1][0]}),
        .in_last(last_v[1][2:0]), .in_valid(vld_v[1][2:0]), .in_ready(ird_b),
        .out_data(od_b), .out_last(ol_b), .out_valid(ov_b), .out_ready(ordy_v[1]),
        .grant_idx(gi_b), .worm_active(wa_b));

    peripheral_dbg_soc_ring_router_mux_rr_param #(.CHANNELS(5), .DATA_WIDTH(8), .OUT_REG(0)) u_c (
        .clk(clk), .rst(rst),
        .in_data({dat_v[2][4][7:0], dat_v[2][3][7:0], dat_v[2][2][7:0], dat_v[2][1][7:0], dat_v[2][0][7:0]}),
        .in_last(last_v[2]), .in_valid(vld_v[2]), .in_ready(ird_c),
        .out_data(od_c), .out_last(ol_c), .out_valid(ov_c), .out_ready(ordy_v[2]),
        .grant_idx(gi_c), .worm_active(wa_c));

    logic [16:0] srcq [15][$];
    bit          held [15];
    logic [15:0] outlog [$];

    int          m_owner [3];
    int          m_lastd [3];
    int          m_prev  [3];
    bit          m_full  [3];
    logic [15:0] m_data  [3];
    logic        m_lastb [3];

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned p_present = 100;
    int          rdy_mode  = 0;
    bit          tog       = 1'b0;
    int          seqn      = 0;
    int          pushed    = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] mk(input int u, input int ch, input int seq);
        if (dw[u] == 8) return {8'h00, ch[3:0], seq[3:0]};
        return {ch[3:0], seq[11:0]};
    endfunction

    task automatic push_pkt(input int u, input int ch, input int len);
        for (int i = 0; i < len; i++) begin
            srcq[u*5+ch].push_back({(i == len - 1), mk(u, ch, seqn)});
            seqn++;
            pushed++;
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            m_owner[u] = -1;
            m_lastd[u] = nch[u] - 1;
            m_prev[u]  = 0;
            m_full[u]  = 1'b0;
            m_data[u]  = '0;
            m_lastb[u] = 1'b0;
            vld_v[u]   = '0;
            last_v[u]  = '0;
            ordy_v[u]  = 1'b0;
            for (int c = 0; c < 5; c++) begin
                dat_v[u][c] = '0;
                srcq[u*5+c].delete();
                held[u*5+c] = 1'b0;
            end
        end
    endtask

    function automatic bit pending(input int u);
        for (int c = 0; c < nch[u]; c++) if (srcq[u*5+c].size() != 0) return 1'b1;
        return m_full[u];
    endfunction

    task automatic get_obs(input int u, output logic [4:0] ird, output logic [15:0] od,
                           output logic ol, output logic ov, output logic [2:0] gi, output logic wa);
        case (u)
            0: begin ird = {1'b0, ird_a}; od = od_a; ol = ol_a; ov = ov_a; gi = {1'b0, gi_a}; wa = wa_a; end
            1: begin ird = {2'b0, ird_b}; od = od_b; ol = ol_b; ov = ov_b; gi = {1'b0, gi_b}; wa = wa_b; end
            default: begin ird = ird_c; od = {8'h00, od_c}; ol = ol_c; ov = ov_c; gi = gi_c; wa = wa_c; end
        endcase
    endtask

    // A source holds a presented flit until it is accepted; between flits it may idle.
    task automatic drive_inputs(input int u);
        logic [16:0] h;
        for (int c = 0; c < nch[u]; c++) begin
            int k = u*5 + c;
            if (!held[k] && srcq[k].size() > 0 && $urandom_range(0, 99) < p_present) held[k] = 1'b1;
            vld_v[u][c] = held[k];
            if (held[k]) begin
                h = srcq[k][0];
                last_v[u][c] = h[16];
                dat_v[u][c]  = h[15:0];
            end else begin
                last_v[u][c] = 1'b0;
                dat_v[u][c]  = '0;
            end
        end
        case (rdy_mode)
            0: ordy_v[u] = 1'b1;
            1: ordy_v[u] = 1'b0;
            2: ordy_v[u] = 1'($urandom_range(0, 1));
            default: begin tog = !tog; ordy_v[u] = tog; end
        endcase
    endtask

    task automatic model_check(input int u);
        logic [4:0] ird, exp_ird; logic [15:0] od, d; logic ol, ov, wa, lastf, anyv, r, space;
        logic [2:0] gi;
        int ch, c, n;
        n = nch[u];
        get_obs(u, ird, od, ol, ov, gi, wa);
        check_eq($sformatf("u%0d_worm_active", u), wa, (m_owner[u] >= 0));
        if (m_owner[u] >= 0) ch = m_owner[u];
        else begin
            ch = -1;
            for (int k = 1; k <= n; k++) begin
                c = (m_lastd[u] + k) % n;
                if (ch < 0 && vld_v[u][c]) ch = c;
            end
            if (ch < 0) ch = m_prev[u];
        end
        anyv  = vld_v[u][ch];
        lastf = last_v[u][ch];
        d     = dat_v[u][ch];
        r     = ordy_v[u];
        if (oreg[u] == 0) begin
            exp_ird = r ? (5'd1 << ch) : 5'd0;
            check_eq($sformatf("u%0d_out_valid", u), ov, anyv);
            if (anyv) begin
                check_eq($sformatf("u%0d_out_data", u), od, d);
                check_eq($sformatf("u%0d_out_last", u), ol, lastf);
            end
            if (anyv && r) outlog.push_back(d);
            if (anyv) begin
                if (r && lastf) begin m_owner[u] = -1; m_lastd[u] = ch; end
                else m_owner[u] = ch;
            end
        end else begin
            space   = !m_full[u] || r;
            exp_ird = space ? (5'd1 << ch) : 5'd0;
            check_eq($sformatf("u%0d_out_valid", u), ov, m_full[u]);
            if (m_full[u]) begin
                check_eq($sformatf("u%0d_out_data", u), od, m_data[u]);
                check_eq($sformatf("u%0d_out_last", u), ol, m_lastb[u]);
                if (r) outlog.push_back(m_data[u]);
            end
            if (anyv && space) begin
                m_data[u] = d; m_lastb[u] = lastf; m_full[u] = 1'b1;
                if (lastf) begin m_owner[u] = -1; m_lastd[u] = ch; end
                else m_owner[u] = ch;
            end else if (r) m_full[u] = 1'b0;
        end
        m_prev[u] = ch;
        check_eq($sformatf("u%0d_in_ready", u), ird, exp_ird);
        check_eq($sformatf("u%0d_grant_idx", u), gi, ch);
        check_eq($sformatf("u%0d_grant_range", u), (int'(gi) < n), 1);
        for (int cc = 0; cc < n; cc++) begin
            if (vld_v[u][cc] && ird[cc]) begin
                void'(srcq[u*5+cc].pop_front());
                held[u*5+cc] = 1'b0;
            end
        end
    endtask

    task automatic run_cycle(input int u);
        @(negedge clk);
        drive_inputs(u);
        #1;
        model_check(u);
    endtask

    task automatic idle(input int u);
        @(negedge clk);
        vld_v[u]  = '0;
        ordy_v[u] = 1'b0;
    endtask

    task automatic drain(input int u, input int maxc, output int cyc);
        cyc = 0;
        while (pending(u) && cyc < maxc) begin
            run_cycle(u);
            cyc++;
        end
        check_eq($sformatf("u%0d_drain_timeout", u), pending(u), 0);
        idle(u);
    endtask

    task automatic check_log_ch(input string tag, input int hi, input int lo, input int exp [$]);
        logic [15:0] e;
        logic [3:0]  cn;
        check_eq({tag, "_count"}, outlog.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            e  = (i < outlog.size()) ? outlog[i] : 16'hFFFF;
            cn = (hi == 15) ? e[15:12] : e[7:4];
            check_eq($sformatf("%s_%0d", tag, i), cn, exp[i]);
        end
    endtask

    task automatic random_phase(input int u, input int cycles);
        int c, cyc;
        outlog.delete();
        pushed    = 0;
        p_present = 70;
        rdy_mode  = 2;
        repeat (cycles) begin
            c = $urandom_range(0, nch[u] - 1);
            if (srcq[u*5+c].size() < 6 && $urandom_range(0, 2) == 0) push_pkt(u, c, $urandom_range(1, 4));
            run_cycle(u);
        end
        p_present = 100;
        rdy_mode  = 0;
        drain(u, 400, cyc);
        check_eq($sformatf("u%0d_rand_count", u), outlog.size(), pushed);
    endtask

    initial begin
        logic [4:0] ird; logic [15:0] od; logic ol, ov, wa; logic [2:0] gi;
        logic [15:0] e;
        int cyc;

        model_reset();
        #12;
        for (int u = 0; u < 3; u++) begin
            get_obs(u, ird, od, ol, ov, gi, wa);
            check_eq($sformatf("u%0d_rst_valid", u), ov, 0);
            check_eq($sformatf("u%0d_rst_data", u), od, 0);
            check_eq($sformatf("u%0d_rst_last", u), ol, 0);
            check_eq($sformatf("u%0d_rst_ready", u), ird, 0);
            check_eq($sformatf("u%0d_rst_grant", u), gi, 0);
            check_eq($sformatf("u%0d_rst_worm", u), wa, 0);
        end
        @(negedge clk);
        rst = 1'b1;

        // 4 channels, single-flit packets, all valid: strict rotation, one flit per cycle.
        p_present = 100; rdy_mode = 0; outlog.delete();
        for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) push_pkt(0, c, 1);
        drain(0, 50, cyc);
        check_eq("rr_cycles", cyc, 8);
        check_log_ch("rr_order", 15, 12, '{0, 1, 2, 3, 0, 1, 2, 3});

        // ch2 worm of three flits while ch0 and ch3 wait.
        push_pkt(0, 1, 1);
        drain(0, 20, cyc);
        outlog.delete();
        push_pkt(0, 2, 3); push_pkt(0, 0, 1); push_pkt(0, 3, 1);
        drain(0, 30, cyc);
        check_log_ch("worm_order", 15, 12, '{2, 2, 2, 3, 0});

        // ch1 stalls with 0xA5A5 for three cycles while ch0 is valid.
        outlog.delete();
        srcq[1].push_back({1'b1, 16'hA5A5});
        push_pkt(0, 0, 1);
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) begin
            run_cycle(0);
            check_eq("stall_data", od_a, 16'hA5A5);
            check_eq("stall_grant", gi_a, 1);
            if (i > 0) check_eq("stall_worm", wa_a, 1);
        end
        rdy_mode = 0;
        drain(0, 20, cyc);
        e = (outlog.size() > 0) ? outlog[0] : 16'h0000;
        check_eq("stall_first", e, 16'hA5A5);
        check_log_ch("stall_order", 15, 12, '{10, 0});

        // Asynchronous reset in the middle of a 4-flit worm from ch0.
        push_pkt(0, 0, 4);
        run_cycle(0);
        @(negedge clk);
        drive_inputs(0);
        #1;
        check_eq("pre_rst_worm", wa_a, 1);
        rst = 1'b0;
        #1;
        check_eq("arst_valid", ov_a, 0);
        check_eq("arst_worm", wa_a, 0);
        check_eq("arst_grant", gi_a, 0);
        check_eq("arst_ready", ird_a, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        push_pkt(0, 3, 1);
        run_cycle(0);
        check_eq("post_rst_grant", gi_a, 3);
        check_eq("post_rst_valid", ov_a, 1);
        drain(0, 20, cyc);

        // 5 channels: ch4 alone then ch0 alone, pointer wraps 4 -> 0.
        outlog.delete();
        push_pkt(2, 4, 1);
        drain(2, 20, cyc);
        push_pkt(2, 0, 1);
        drain(2, 20, cyc);
        check_log_ch("wrap_order", 7, 4, '{4, 0});

        // Registered output: one cycle latency and one flit per cycle across packets.
        outlog.delete();
        pushed = 0;
        push_pkt(1, 0, 6); push_pkt(1, 1, 2);
        drain(1, 40, cyc);
        check_eq("oreg_cycles", cyc, 9);
        check_eq("oreg_count", outlog.size(), 8);

        // Registered output with out_ready toggling every cycle.
        outlog.delete();
        pushed = 0;
        rdy_mode = 3;
        for (int c = 0; c < 3; c++) begin push_pkt(1, c, 3); push_pkt(1, c, 1); end
        drain(1, 200, cyc);
        check_eq("toggle_count", outlog.size(), pushed);
        rdy_mode = 0;

        for (int u = 0; u < 3; u++) random_phase(u, 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench timeout");
    end

endmodule
